// File: rtl/signed_multiplier_pkg.sv
// Shared widths and state encoding for the sign-magnitude multiplier slice.
package signed_multiplier_pkg;
   localparam int OP_W   = 5;
   localparam int MAG_W  = 4;
   localparam int P_W    = 9;
   localparam int PMAG_W = 8;

   typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/signed_multiplier_if.sv
// Request/result bundle between a datapath client and the multiplier.
interface signed_multiplier_if;
   import signed_multiplier_pkg::*;

   logic             start;
   logic [OP_W-1:0]  mi1;
   logic [OP_W-1:0]  mi2;
   logic [P_W-1:0]   P;
   logic             busy;
   logic             done;

   modport master (output start, mi1, mi2, input P, busy, done);
   modport slave  (input start, mi1, mi2, output P, busy, done);
endinterface

// File: rtl/signed_multiplier_sign_mag_pack.sv
// Forms the sign-magnitude product word; a zero magnitude always carries a + sign.
module sm_sign_mag_pack
   import signed_multiplier_pkg::*;
(
   input  logic              sign,
   input  logic [PMAG_W-1:0] mag,
   output logic [P_W-1:0]    p
);
   function automatic logic [P_W-1:0] pack_sm(input logic s, input logic [PMAG_W-1:0] m);
      return {s & (m != '0), m};
   endfunction

   assign p = pack_sm(sign, mag);
endmodule

// File: rtl/signed_multiplier.sv
// Shift-add sign-magnitude multiplier: one multiplier bit per clock, result 4 clocks after start.
module signed_multiplier
   import signed_multiplier_pkg::*;
(
   input logic                clk,
   input logic                rst_n,
   signed_multiplier_if.slave mul
);
   state_t            state;
   logic [1:0]        cnt;
   logic [PMAG_W-1:0] acc;
   logic [PMAG_W-1:0] addend;
   logic [PMAG_W-1:0] acc_next;
   logic [MAG_W-1:0]  a_mag;
   logic [MAG_W-1:0]  b_mag;
   logic              sgn;
   logic [P_W-1:0]    p_next;

   // The final partial sum goes straight into P, so the packer sees acc_next.
   always_comb begin
      addend = '0;
      if (b_mag[cnt]) addend = PMAG_W'(a_mag) << cnt;
      acc_next = acc + addend;
   end

   sm_sign_mag_pack u_pack (
      .sign (sgn),
      .mag  (acc_next),
      .p    (p_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         acc      <= '0;
         a_mag    <= '0;
         b_mag    <= '0;
         sgn      <= 1'b0;
         mul.P    <= '0;
         mul.busy <= 1'b0;
         mul.done <= 1'b0;
      end else begin
         mul.done <= 1'b0;
         case (state)
            IDLE: begin
               if (mul.start) begin
                  a_mag    <= mul.mi1[MAG_W-1:0];
                  b_mag    <= mul.mi2[MAG_W-1:0];
                  sgn      <= mul.mi1[OP_W-1] ^ mul.mi2[OP_W-1];
                  acc      <= '0;
                  cnt      <= '0;
                  mul.busy <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               acc <= acc_next;
               cnt <= cnt + 2'd1;
               if (cnt == 2'd3) begin
                  mul.P    <= p_next;
                  mul.done <= 1'b1;
                  mul.busy <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_signed_multiplier.sv
// Directed and sweep bench for signed_multiplier; inputs change and outputs are sampled on falling edges.
module tb_signed_multiplier;
   import signed_multiplier_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   signed_multiplier_if bus ();

   signed_multiplier dut (
      .clk   (clk),
      .rst_n (rst_n),
      .mul   (bus)
   );

   task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [8:0] golden(input logic [4:0] a, input logic [4:0] b);
      logic [7:0] m;
      m = a[3:0] * b[3:0];
      return {(m != 8'd0) & (a[4] ^ b[4]), m};
   endfunction

   // edges counts falling edges from the one after the capture edge up to the one where done is seen.
   task automatic do_mul(input logic [4:0] a, input logic [4:0] b,
                         output logic [8:0] p, output int edges);
      @(negedge clk);
      bus.start = 1'b1;
      bus.mi1   = a;
      bus.mi2   = b;
      @(negedge clk);
      bus.start = 1'b0;
      edges = 1;
      while (bus.done !== 1'b1 && edges < 12) begin
         @(negedge clk);
         edges++;
      end
      p = bus.P;
   endtask

   logic [8:0] p;
   int         edges;
   int         ndone;
   int         first_done;
   int         last_done;
   int         gap_bad;

   initial begin
      bus.start = 1'b0;
      bus.mi1   = '0;
      bus.mi2   = '0;
      rst_n     = 1'b1;
      #2 rst_n  = 1'b0;
      #1;
      chk("rst_P",    16'(bus.P),    16'h000);
      chk("rst_busy", 16'(bus.busy), 16'h0);
      chk("rst_done", 16'(bus.done), 16'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors with hand-computed products.
      do_mul(5'd19, 5'd5, p, edges);
      chk("neg_pos_P",   16'(p), 16'h10F);
      chk("neg_pos_lat", 16'(edges), 16'd5);
      @(negedge clk);
      chk("done_width", 16'(bus.done), 16'h0);
      chk("busy_after", 16'(bus.busy), 16'h0);
      chk("P_hold",     16'(bus.P),    16'h10F);

      do_mul(5'd31, 5'd15, p, edges);
      chk("ext_neg_P", 16'(p), 16'h1E1);
      do_mul(5'd31, 5'd31, p, edges);
      chk("ext_pos_P", 16'(p), 16'h0E1);
      do_mul(5'd16, 5'd7, p, edges);
      chk("negzero_a", 16'(p), 16'h000);
      do_mul(5'd20, 5'd0, p, edges);
      chk("negzero_b", 16'(p), 16'h000);
      do_mul(5'd6, 5'd26, p, edges);
      chk("pos_neg_P", 16'(p), 16'h13C);

      // Operand changes and a second start while running must not disturb the result.
      @(negedge clk);
      bus.start = 1'b1; bus.mi1 = 5'd19; bus.mi2 = 5'd5;
      @(negedge clk);
      bus.start = 1'b0; bus.mi1 = 5'd31; bus.mi2 = 5'd31;
      chk("busy_run", 16'(bus.busy), 16'h1);
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      edges = 3;
      while (bus.done !== 1'b1 && edges < 12) begin
         @(negedge clk);
         edges++;
      end
      chk("prot_lat", 16'(edges), 16'd5);
      chk("prot_P",   16'(bus.P), 16'h10F);
      ndone = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus.done === 1'b1) ndone++;
      end
      chk("no_queue", 16'(ndone), 16'd0);

      // start held high: one result every 5 cycles, sampled across 22 falling edges.
      bus.mi1 = 5'd3; bus.mi2 = 5'd3; bus.start = 1'b1;
      ndone = 0; first_done = -1; last_done = -1; gap_bad = 0;
      for (int n = 1; n <= 22; n++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            if (last_done >= 0 && n - last_done != 5) gap_bad++;
            if (first_done < 0) first_done = n;
            last_done = n;
            ndone++;
         end
      end
      bus.start = 1'b0;
      chk("b2b_count", 16'(ndone), 16'd4);
      chk("b2b_first", 16'(first_done), 16'd5);
      chk("b2b_gap",   16'(gap_bad), 16'd0);
      chk("b2b_P",     16'(bus.P), 16'h009);
      repeat (6) @(negedge clk);

      // Reset in the middle of a run.
      @(negedge clk);
      bus.start = 1'b1; bus.mi1 = 5'd31; bus.mi2 = 5'd31;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_P",    16'(bus.P),    16'h000);
      chk("mid_rst_busy", 16'(bus.busy), 16'h0);
      chk("mid_rst_done", 16'(bus.done), 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus.done === 1'b1) ndone++;
      end
      chk("mid_rst_nodone", 16'(ndone), 16'd0);

      // start presented together with reset release is taken at the first edge.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; bus.start = 1'b1; bus.mi1 = 5'd10; bus.mi2 = 5'd27;
      @(negedge clk);
      bus.start = 1'b0;
      edges = 1;
      while (bus.done !== 1'b1 && edges < 12) begin
         @(negedge clk);
         edges++;
      end
      chk("rel_lat", 16'(edges), 16'd5);
      chk("rel_P",   16'(bus.P), 16'h16E);

      // Sweep: negative mi1 against every mi2 magnitude, then all positive pairs.
      for (int a = 16; a < 32; a++) begin
         for (int b = 0; b < 16; b++) begin
            do_mul(5'(a), 5'(b), p, edges);
            chk("sweep_neg", {edges[6:0], p}, {7'd5, golden(5'(a), 5'(b))});
         end
      end
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            do_mul(5'(a), 5'(b), p, edges);
            chk("sweep_pos", {edges[6:0], p}, {7'd5, golden(5'(a), 5'(b))});
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
